// File: rtl/sync_fifo_fwft_1r1w_pkg.sv
// Shared constants and elaboration helpers for the FWFT FIFO and its RAM core.
package sync_fifo_fwft_1r1w_pkg;

  // RAM read latency seen by the prefetch stage: 1 cycle bare, 2 with an output register.
  function automatic int ram_latency(input bit dout_reg);
    return dout_reg ? 2 : 1;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_1r1w_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable,
// optional extra output register.
module sdp_ram_core #(
  parameter string RAM_STYLE  = "block",
  parameter int    WIDTH_DATA = 64,
  parameter int    WIDTH_ADDR = 5,
  parameter bit    OUT_REG    = 1'b0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [WIDTH_ADDR-1:0] waddr,
  input  logic [WIDTH_DATA-1:0] wdata,
  input  logic                  re,
  input  logic [WIDTH_ADDR-1:0] raddr,
  output logic [WIDTH_DATA-1:0] rdata
);
  localparam int DEPTH = 1 << WIDTH_ADDR;

  logic [WIDTH_DATA-1:0] rd_word;
  logic [WIDTH_DATA-1:0] q;

  generate
    if (RAM_STYLE == "distributed") begin : g_dist
      (* ram_style = "distributed" *) logic [WIDTH_DATA-1:0] mem [DEPTH];
      always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
      assign rd_word = mem[raddr];
    end else if (RAM_STYLE == "registers") begin : g_regs
      (* ram_style = "registers" *) logic [WIDTH_DATA-1:0] mem [DEPTH];
      always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
      assign rd_word = mem[raddr];
    end else if (RAM_STYLE == "block") begin : g_block
      (* ram_style = "block" *) logic [WIDTH_DATA-1:0] mem [DEPTH];
      always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
      assign rd_word = mem[raddr];
    end else begin : g_auto
      logic [WIDTH_DATA-1:0] mem [DEPTH];
      always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
      assign rd_word = mem[raddr];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (re) q <= rd_word;
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [WIDTH_DATA-1:0] q2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q2 <= '0;
        else        q2 <= q;
      end
      assign rdata = q2;
    end else begin : g_noreg
      assign rdata = q;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_fwft_1r1w.sv
// First-word-fall-through FIFO: RAM queue plus a small register prefetch stage
// whose head drives rd_data, sustaining one push and one pop per cycle.
module sync_fifo_fwft_1r1w
  import sync_fifo_fwft_1r1w_pkg::*;
#(
  parameter string RAM_STYLE_MODE = "block",
  parameter int    WIDTH_DATA     = 64,
  parameter int    WIDTH_ADDR     = 5,
  parameter string DOUT_REG       = "false",
  parameter int    AFULL_THRESH   = (1 << WIDTH_ADDR) - 4,
  parameter int    AEMPTY_THRESH  = 2
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH_DATA-1:0] wr_data,
  output logic                  full,
  output logic                  afull,
  input  logic                  rd_en,
  output logic [WIDTH_DATA-1:0] rd_data,
  output logic                  empty,
  output logic                  aempty,
  output logic [WIDTH_ADDR:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH   = 1 << WIDTH_ADDR;
  localparam bit OUT_REG = (DOUT_REG == "true");
  localparam int L       = ram_latency(OUT_REG);
  localparam int P       = L + 1;
  localparam int PF_CW   = clog2(P + 1);
  localparam int CW      = WIDTH_ADDR + 1;

  logic                         push, pop, issue, land;
  logic [WIDTH_ADDR-1:0]        wp, rp;
  logic [CW-1:0]                ram_cnt, count_nxt;
  logic [PF_CW-1:0]             pf_cnt, wi;
  logic [PF_CW:0]               pf_need;
  logic [L-1:0]                 vld_pipe;
  logic [P-1:0][WIDTH_DATA-1:0] pf_data;
  logic [WIDTH_DATA-1:0]        ram_rdata;

  assign push      = wr_en & ~full;
  assign pop       = rd_en & ~empty;
  assign empty     = (pf_cnt == '0);
  assign rd_data   = pf_data[0];
  assign land      = vld_pipe[L-1];
  assign wi        = pf_cnt - PF_CW'(pop);
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Prefetch slots already spoken for: held entries plus reads still in the RAM pipe.
  // Crediting this cycle's pop keeps streaming bubble-free.
  always_comb begin
    pf_need = {1'b0, pf_cnt};
    for (int i = 0; i < L; i++) pf_need = pf_need + (PF_CW + 1)'(vld_pipe[i]);
  end

  // ram_cnt only counts writes from earlier cycles, so rp never equals a live wp.
  assign issue = (ram_cnt != '0) && (int'(pf_need) < P + int'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      ram_cnt   <= '0;
      count     <= '0;
      pf_cnt    <= '0;
      vld_pipe  <= '0;
      full      <= 1'b0;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push)  wp <= wp + 1'b1;
      if (issue) rp <= rp + 1'b1;
      ram_cnt   <= ram_cnt + CW'(push) - CW'(issue);
      count     <= count_nxt;
      pf_cnt    <= pf_cnt + PF_CW'(land) - PF_CW'(pop);
      vld_pipe[0] <= issue;
      for (int i = 1; i < L; i++) vld_pipe[i] <= vld_pipe[i-1];
      full      <= (count_nxt == CW'(DEPTH));
      afull     <= (int'(count_nxt) >= AFULL_THRESH);
      aempty    <= (int'(count_nxt) <= AEMPTY_THRESH);
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  // Prefetch register FIFO: slot 0 is the head; a landing read fills the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_data <= '0;
    end else begin
      if (pop)
        for (int i = 0; i < P - 1; i++) pf_data[i] <= pf_data[i+1];
      for (int i = 0; i < P; i++)
        if (land && wi == PF_CW'(i)) pf_data[i] <= ram_rdata;
    end
  end

  sdp_ram_core #(
    .RAM_STYLE  (RAM_STYLE_MODE),
    .WIDTH_DATA (WIDTH_DATA),
    .WIDTH_ADDR (WIDTH_ADDR),
    .OUT_REG    (OUT_REG)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wp),
    .wdata (wr_data),
    .re    (issue),
    .raddr (rp),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sync_fifo_fwft_1r1w.sv
// Directed bench: one FIFO with a bare RAM read, one with the RAM output register.
module tb_sync_fifo_fwft_1r1w;
  localparam int W = 64;
  localparam int A = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         wr_en0 = 0, rd_en0 = 0, wr_en1 = 0, rd_en1 = 0;
  logic [W-1:0] wr_data0 = '0, wr_data1 = '0;
  logic [W-1:0] rd_data0, rd_data1;
  logic         full0, afull0, empty0, aempty0, overflow0, underflow0;
  logic         full1, afull1, empty1, aempty1, overflow1, underflow1;
  logic [A:0]   count0, count1;

  int checks = 0;
  int errors = 0;

  sync_fifo_fwft_1r1w #(.WIDTH_DATA(W), .WIDTH_ADDR(A), .DOUT_REG("false")) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_data(wr_data0), .full(full0),
    .afull(afull0), .rd_en(rd_en0), .rd_data(rd_data0), .empty(empty0),
    .aempty(aempty0), .count(count0), .overflow(overflow0), .underflow(underflow0));

  sync_fifo_fwft_1r1w #(.WIDTH_DATA(W), .WIDTH_ADDR(A), .DOUT_REG("true")) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data1), .full(full1),
    .afull(afull1), .rd_en(rd_en1), .rd_data(rd_data1), .empty(empty1),
    .aempty(aempty1), .count(count1), .overflow(overflow1), .underflow(underflow1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if ({empty0, aempty0, full0, afull0, overflow0, underflow0} !== 6'b110000) begin
      errors++; $display("FAIL reset_flags0 got %b exp 110000", {empty0, aempty0, full0, afull0, overflow0, underflow0}); end
    checks++; if (count0 !== 6'd0) begin errors++; $display("FAIL reset_count0 got %0d exp 0", count0); end
    checks++; if (rd_data0 !== 64'd0) begin errors++; $display("FAIL reset_rd_data0 got %0h exp 0", rd_data0); end
    checks++; if ({empty1, aempty1, full1, afull1, overflow1, underflow1} !== 6'b110000) begin
      errors++; $display("FAIL reset_flags1 got %b exp 110000", {empty1, aempty1, full1, afull1, overflow1, underflow1}); end
    checks++; if (count1 !== 6'd0) begin errors++; $display("FAIL reset_count1 got %0d exp 0", count1); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    wr_en0 = 1; wr_data0 = 64'hA5;
    tick(); wr_en0 = 0;
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL single_empty_T got %b exp 1", empty0); end
    checks++; if (count0 !== 6'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count0); end
    tick();
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL single_empty_T1 got %b exp 1", empty0); end
    tick();
    checks++; if (empty0 !== 1'b0) begin errors++; $display("FAIL single_empty_T2 got %b exp 0", empty0); end
    checks++; if (rd_data0 !== 64'hA5) begin errors++; $display("FAIL single_data got %0h exp a5", rd_data0); end
    rd_en0 = 1; tick(); rd_en0 = 0;
    checks++; if (empty0 !== 1'b1 || count0 !== 6'd0) begin
      errors++; $display("FAIL single_pop got empty=%b count=%0d exp empty=1 count=0", empty0, count0); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      wr_en0 = 1; wr_data0 = 64'(i);
      tick();
      checks++; if (count0 !== 6'(i + 1) || full0 !== (i == 31) || afull0 !== (i + 1 >= 28)) begin
        errors++; $display("FAIL fill_%0d got count=%0d full=%b afull=%b exp count=%0d full=%b afull=%b",
          i, count0, full0, afull0, i + 1, (i == 31), (i + 1 >= 28)); end
    end
    wr_data0 = 64'hDEAD;
    tick(); wr_en0 = 0;
    checks++; if (overflow0 !== 1'b1 || count0 !== 6'd32 || full0 !== 1'b1) begin
      errors++; $display("FAIL fill_overflow got ovf=%b count=%0d full=%b exp 1 32 1", overflow0, count0, full0); end
    tick();
    checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL fill_overflow_clear got %b exp 0", overflow0); end
    for (int i = 0; i < 32; i++) begin
      checks++; if (empty0 !== 1'b0 || rd_data0 !== 64'(i)) begin
        errors++; $display("FAIL drain_%0d got empty=%b data=%0h exp empty=0 data=%0h", i, empty0, rd_data0, i); end
      rd_en0 = 1; tick();
    end
    rd_en0 = 0;
    checks++; if (empty0 !== 1'b1 || count0 !== 6'd0) begin
      errors++; $display("FAIL drain_end got empty=%b count=%0d exp 1 0", empty0, count0); end
  endtask

  task automatic test_stream();
    logic [W-1:0] nwr, nrd;
    for (int i = 0; i < 3; i++) begin wr_en0 = 1; wr_data0 = 64'(100 + i); tick(); end
    wr_en0 = 0;
    repeat (3) tick();
    nwr = 64'd103; nrd = 64'd100;
    for (int c = 0; c < 100; c++) begin
      checks++; if (empty0 !== 1'b0 || rd_data0 !== nrd) begin
        errors++; $display("FAIL stream_head_%0d got empty=%b data=%0d exp empty=0 data=%0d", c, empty0, rd_data0, nrd); end
      wr_en0 = 1; wr_data0 = nwr; rd_en0 = 1;
      tick();
      nwr++; nrd++;
      checks++; if (count0 !== 6'd3) begin errors++; $display("FAIL stream_count_%0d got %0d exp 3", c, count0); end
    end
    wr_en0 = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (empty0 !== 1'b0 || rd_data0 !== nrd) begin
        errors++; $display("FAIL stream_tail_%0d got empty=%b data=%0d exp empty=0 data=%0d", i, empty0, rd_data0, nrd); end
      tick(); nrd++;
    end
    rd_en0 = 0;
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL stream_end_empty got %b exp 1", empty0); end
  endtask

  task automatic test_underflow();
    rd_en0 = 1; tick(); rd_en0 = 0;
    checks++; if (underflow0 !== 1'b1 || empty0 !== 1'b1 || count0 !== 6'd0) begin
      errors++; $display("FAIL underflow got udf=%b empty=%b count=%0d exp 1 1 0", underflow0, empty0, count0); end
    tick();
    checks++; if (underflow0 !== 1'b0) begin errors++; $display("FAIL underflow_clear got %b exp 0", underflow0); end
    wr_en0 = 1; wr_data0 = 64'h5A; rd_en0 = 1;
    tick(); wr_en0 = 0; rd_en0 = 0;
    checks++; if (underflow0 !== 1'b1 || count0 !== 6'd1) begin
      errors++; $display("FAIL pushpop_empty got udf=%b count=%0d exp 1 1", underflow0, count0); end
    tick(); tick();
    checks++; if (empty0 !== 1'b0 || rd_data0 !== 64'h5A) begin
      errors++; $display("FAIL pushpop_empty_data got empty=%b data=%0h exp 0 5a", empty0, rd_data0); end
    rd_en0 = 1; tick(); rd_en0 = 0;
    checks++; if (count0 !== 6'd0) begin errors++; $display("FAIL pushpop_empty_pop got %0d exp 0", count0); end
  endtask

  task automatic test_dout_reg();
    wr_en1 = 1; wr_data1 = 64'hB0;
    tick(); wr_en1 = 0;
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL doreg_empty_T got %b exp 1", empty1); end
    tick();
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL doreg_empty_T1 got %b exp 1", empty1); end
    tick();
    checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL doreg_empty_T2 got %b exp 1", empty1); end
    tick();
    checks++; if (empty1 !== 1'b0 || rd_data1 !== 64'hB0) begin
      errors++; $display("FAIL doreg_T3 got empty=%b data=%0h exp 0 b0", empty1, rd_data1); end
    for (int i = 1; i < 6; i++) begin wr_en1 = 1; wr_data1 = 64'(8'hB0 + i); tick(); end
    wr_en1 = 0;
    repeat (4) tick();
    for (int i = 0; i < 6; i++) begin
      checks++; if (empty1 !== 1'b0 || rd_data1 !== 64'(8'hB0 + i)) begin
        errors++; $display("FAIL doreg_pop_%0d got empty=%b data=%0h exp empty=0 data=%0h", i, empty1, rd_data1, 8'hB0 + i); end
      rd_en1 = 1; tick();
    end
    rd_en1 = 0;
    checks++; if (empty1 !== 1'b1 || count1 !== 6'd0) begin
      errors++; $display("FAIL doreg_end got empty=%b count=%0d exp 1 0", empty1, count1); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin wr_en0 = 1; wr_data0 = 64'(200 + i); tick(); end
    wr_en0 = 0; tick();
    checks++; if (count0 !== 6'd10) begin errors++; $display("FAIL rmid_prefill got %0d exp 10", count0); end
    wr_en0 = 1; wr_data0 = 64'd999;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({empty0, aempty0, full0, afull0, overflow0, underflow0} !== 6'b110000) begin
      errors++; $display("FAIL rmid_flags got %b exp 110000", {empty0, aempty0, full0, afull0, overflow0, underflow0}); end
    checks++; if (count0 !== 6'd0 || rd_data0 !== 64'd0) begin
      errors++; $display("FAIL rmid_state got count=%0d data=%0h exp 0 0", count0, rd_data0); end
    wr_en0 = 0;
    #2 rst_n = 1'b1;
    tick();
    wr_en0 = 1; wr_data0 = 64'h77;
    tick(); wr_en0 = 0;
    tick();
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL rmid_empty_T1 got %b exp 1", empty0); end
    tick();
    checks++; if (empty0 !== 1'b0 || rd_data0 !== 64'h77 || count0 !== 6'd1) begin
      errors++; $display("FAIL rmid_push got empty=%b data=%0h count=%0d exp 0 77 1", empty0, rd_data0, count0); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_underflow();
    test_dout_reg();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft_1r1w.md
Name: sync_fifo_fwft_1r1w

Overview:
- Single-clock, parametrised first-word-fall-through (FWFT) FIFO built on an inferred simple-dual-port RAM.
- Adds a small register prefetch stage that hides RAM read latency: optional output register, one push and one pop per cycle sustained.
- Provides occupancy count, almost-full/almost-empty flags and overflow/underflow error pulses.
- Used as the generic queue in TX datapaths: descriptor and payload staging.

Parameters:
- RAM_STYLE_MODE, "block": RAM inference hint; one of "block", "distributed", "registers", "auto".
- WIDTH_DATA, 64: entry width in bits.
- WIDTH_ADDR, 5: RAM address width; DEPTH = 2**WIDTH_ADDR entries.
- DOUT_REG, "false": "true" adds a RAM output register, so RAM read latency L = 2 instead of 1.
- AFULL_THRESH, DEPTH-4: afull asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2: aempty asserts when count <= AEMPTY_THRESH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request.
- wr_data  in  WIDTH_DATA  push data.
- full  out  1  no push accepted this cycle.
- afull  out  1  count >= AFULL_THRESH.
- rd_en  in  1  pop request (acknowledges rd_data).
- rd_data  out  WIDTH_DATA  head entry; valid while empty=0.
- empty  out  1  no valid head entry.
- aempty  out  1  count <= AEMPTY_THRESH.
- count  out  WIDTH_ADDR+1  accepted pushes minus pops, range 0..DEPTH.
- overflow  out  1  one-cycle pulse: push attempted while full.
- underflow  out  1  one-cycle pulse: pop attempted while empty.

Behaviour:
- Reset (async assert, sync release), all registers cleared:
  - empty=1, aempty=1, full=0, afull=0, count=0.
  - rd_data=0, overflow=0, underflow=0.
  - Pointers and prefetch occupancy cleared.
  - RAM contents are not cleared.
- Reset mid-operation: all queued data is discarded; the first push after release behaves as a push into an empty FIFO.
- Push and pop acceptance:
  - push accepted = wr_en & !full.
  - pop accepted = rd_en & !empty.
  - A rejected push has no effect except a registered overflow pulse in the next cycle. A rejected pop behaves the same way with underflow.
- Count and flags:
  - count updates the cycle after acceptance: +1 for push only, -1 for pop only, unchanged for both or neither.
  - full, afull and aempty are registered and derived from the next count value, so they are valid in the same cycle count changes.
  - full = (count == DEPTH). Capacity is exactly DEPTH entries, counted across RAM plus prefetch stage.
- Storage structure:
  - Write pointer wp and RAM-read pointer rp, each WIDTH_ADDR bits, wrap modulo DEPTH.
  - RAM-resident entry count is tracked separately from prefetch occupancy.
- Prefetch stage: register FIFO of L+1 entries.
  - Issue a RAM read when the RAM holds at least one entry written in an earlier cycle, and prefetch occupancy plus in-flight reads < L+1.
  - Never read an address in the same cycle it is written; no read-during-write bypass is required.
  - In-flight reads land in the prefetch stage after L cycles.
  - Head register drives rd_data; empty = (prefetch occupancy == 0).
- Latency:
  - Push at cycle T into an empty FIFO gives empty=0 with valid rd_data at T+2 (DOUT_REG "false") or T+3 ("true").
  - Pop at T exposes the next entry at T+1 if it is prefetched.
- Throughput: continuous push plus pop at steady state, with no bubbles on either side.
- Simultaneous push and pop:
  - When full: the pop is accepted; the push is rejected (full is sampled) and pulses overflow.
  - When empty: the push is accepted; the pop is rejected and pulses underflow.
- Ordering: strict FIFO across pointer wrap. rd_data holds stable while empty=0 and rd_en=0.

Decomposition:
- Shared include: ram_latency function (1 or 2 from DOUT_REG) and a clog2 helper; no typedefs in this Verilog code.
- Natural sub-module: sdp_ram_core, a parametrised 1-write/1-read RAM with read enable and optional output register.
- Prefetch logic and pointers stay in the top module.

Test Plan:
- DOUT_REG "false": reset, push 0xA5 at T -> empty falls at T+2, rd_data=0xA5, count=1; pop -> empty=1, count=0.
- Push 32 entries 0..31 (DEPTH=32) -> full=1 at the 32nd, afull from count 28; a 33rd push -> overflow pulse, count stays 32; pops return 0..31 in order.
- Continuous push plus pop for 100 cycles after prefill of 3 -> no bubble, count stays 3, data sequential across pointer wrap.
- Pop on empty -> underflow pulse for 1 cycle, state unchanged; simultaneous push and pop on empty -> push accepted, underflow=1.
- DOUT_REG "true": push at T -> empty falls at T+3; back-to-back pops sustain 1 entry per cycle.
- Assert rst_n low mid-stream with count=10 -> outputs at reset values immediately; next push 0x77 at T -> rd_data=0x77 at T+2.
